// File: rtl/cp_symbol_framer_pkg.sv
// Shared definitions for the CP symbol framer and the FFT-side address generators:
// default symbol size, read-FSM state encoding and the bit-reversal helper.
package cp_symbol_framer_pkg;

  localparam int unsigned CPF_N     = 64;
  localparam int unsigned CPF_LOG2N = 6;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_RUN  = 1'b1
  } rd_state_t;

  // Reverses the low 'bits' bits of v; everything above 'bits' returns as zero.
  function automatic logic [31:0] bitrev(input logic [31:0] v, input int unsigned bits);
    logic [31:0] r;
    r = '0;
    for (int unsigned k = 0; k < 32; k++) begin
      if (k < bits) r[5'(bits - 1 - k)] = v[5'(k)];
    end
    return r;
  endfunction

endpackage

// File: rtl/cp_symbol_framer_symbol_dpram.sv
// Simple dual-port symbol RAM: one write port, one registered read port.
// The two banks of the ping-pong buffer are the top address bit.
module cp_symbol_framer_symbol_dpram
  import cp_symbol_framer_pkg::*;
#(
  parameter int unsigned DEPTH = 2 * CPF_N,
  parameter int unsigned AW    = CPF_LOG2N + 1,
  parameter int unsigned W     = 32
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [W-1:0]  o_rdata
);

  logic [W-1:0] r_mem [DEPTH];
  logic [W-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Read register is reset so the framer's data outputs start at zero.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/cp_symbol_framer.sv
// Collects the CP-stripped sample stream into whole N-point symbols in a ping-pong
// buffer and replays each symbol to the FFT in bit-reversed or natural order.
module cp_symbol_framer
  import cp_symbol_framer_pkg::*;
#(
  parameter int unsigned N      = CPF_N,
  parameter int unsigned LOG2N  = CPF_LOG2N,
  parameter bit          BITREV = 1'b1
) (
  input  logic        CLK_I,
  input  logic        RST_I,
  input  logic [15:0] DAT_I_r,
  input  logic [15:0] DAT_I_i,
  input  logic        ACK_I,
  input  logic        RDY_I,
  output logic [15:0] DAT_O_r,
  output logic [15:0] DAT_O_i,
  output logic        ACK_O,
  output logic        SOF_O,
  output logic        OVF_O,
  output rd_state_t   o_rd_state
);

  // Flow control: ACK_I is a push-only valid (one sample per high cycle, never
  // back-pressured; a sample with nowhere to go is dropped and OVF_O latches).
  // RDY_I gates every read issue; ACK_O/SOF_O/DAT_O follow each issue by one cycle.

  localparam logic [LOG2N-1:0] IDX_LAST = LOG2N'(N - 1);

  logic             r_wr_bank;
  logic [LOG2N-1:0] r_wr_addr;
  logic [1:0]       r_full;
  logic [1:0]       w_full_next;
  logic             r_rd_bank;
  logic [LOG2N-1:0] r_rd_cnt;
  rd_state_t        r_state;
  rd_state_t        w_state_next;
  logic             w_issue;
  logic             w_release;
  logic             w_accept;
  logic             w_wr_done;
  logic [LOG2N-1:0] w_rd_idx;
  logic [31:0]      w_rdata;
  logic             r_ack;
  logic             r_sof;
  logic             r_ovf;

  // A read release of the bank the writer is waiting on frees it in the same cycle.
  assign w_release = w_issue && (r_rd_cnt == IDX_LAST);
  assign w_accept  = ACK_I && (!r_full[r_wr_bank] || (w_release && (r_rd_bank == r_wr_bank)));
  assign w_wr_done = w_accept && (r_wr_addr == IDX_LAST);
  assign w_rd_idx  = BITREV ? LOG2N'(bitrev(32'(r_rd_cnt), LOG2N)) : r_rd_cnt;

  // Write-complete and read-release always hit different banks, so both apply.
  always_comb begin
    w_full_next = r_full;
    if (w_release) w_full_next[r_rd_bank] = 1'b0;
    if (w_wr_done) w_full_next[r_wr_bank] = 1'b1;
  end

  // IDLE issues straight away when its bank is full, so a symbol finishing just as
  // the previous one drains still follows with no bubble.
  always_comb begin
    w_state_next = r_state;
    w_issue      = 1'b0;
    case (r_state)
      R_IDLE: begin
        if (r_full[r_rd_bank]) begin
          w_state_next = R_RUN;
          w_issue      = RDY_I;
        end
      end
      R_RUN: begin
        w_issue = RDY_I;
      end
      default: begin
        w_state_next = R_IDLE;
      end
    endcase
    if (w_release && !r_full[~r_rd_bank]) w_state_next = R_IDLE;
  end

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      r_state <= R_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      r_wr_bank <= 1'b0;
      r_wr_addr <= '0;
      r_full    <= 2'b00;
      r_rd_bank <= 1'b0;
      r_rd_cnt  <= '0;
      r_ack     <= 1'b0;
      r_sof     <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      r_full <= w_full_next;
      if (w_accept) begin
        if (w_wr_done) begin
          r_wr_addr <= '0;
          r_wr_bank <= ~r_wr_bank;
        end else begin
          r_wr_addr <= r_wr_addr + 1'b1;
        end
      end
      if (w_issue) begin
        if (w_release) begin
          r_rd_cnt  <= '0;
          r_rd_bank <= ~r_rd_bank;
        end else begin
          r_rd_cnt <= r_rd_cnt + 1'b1;
        end
      end
      if (ACK_I && !w_accept) r_ovf <= 1'b1;
      r_ack <= w_issue;
      r_sof <= w_issue && (r_rd_cnt == '0);
    end
  end

  cp_symbol_framer_symbol_dpram #(
    .DEPTH(2 * N),
    .AW   (LOG2N + 1),
    .W    (32)
  ) u_ram (
    .i_clk  (CLK_I),
    .i_rst_n(RST_I),
    .i_we   (w_accept),
    .i_waddr({r_wr_bank, r_wr_addr}),
    .i_wdata({DAT_I_r, DAT_I_i}),
    .i_re   (w_issue),
    .i_raddr({r_rd_bank, w_rd_idx}),
    .o_rdata(w_rdata)
  );

  assign DAT_O_r    = w_rdata[31:16];
  assign DAT_O_i    = w_rdata[15:0];
  assign ACK_O      = r_ack;
  assign SOF_O      = r_sof;
  assign OVF_O      = r_ovf;
  assign o_rd_state = r_state;

endmodule

// File: tb/tb_cp_symbol_framer.sv
// Bench for cp_symbol_framer: a bit-reversed and a natural-order instance share one
// input stream; a symbol-level model feeds per-instance expected queues.
module tb_cp_symbol_framer;
  import cp_symbol_framer_pkg::*;

  localparam int N     = 64;
  localparam int LOG2N = 6;

  typedef struct {
    int          cyc;
    logic        sof;
    logic [15:0] r;
    logic [15:0] i;
  } rec_t;

  // ---------------- clock / reset ----------------
  logic clk    = 1'b0;
  logic rst_n  = 1'b1;
  logic [15:0] dat_r = '0;
  logic [15:0] dat_i = '0;
  logic ack_in = 1'b0;
  logic rdy    = 1'b0;

  always #5 clk = ~clk;

  logic [15:0] br_dat_r, br_dat_i, nat_dat_r, nat_dat_i;
  logic        br_ack, br_sof, br_ovf, nat_ack, nat_sof, nat_ovf;
  rd_state_t   br_state, nat_state;

  cp_symbol_framer #(.N(N), .LOG2N(LOG2N), .BITREV(1'b1)) dut_br (
    .CLK_I(clk), .RST_I(rst_n), .DAT_I_r(dat_r), .DAT_I_i(dat_i),
    .ACK_I(ack_in), .RDY_I(rdy), .DAT_O_r(br_dat_r), .DAT_O_i(br_dat_i),
    .ACK_O(br_ack), .SOF_O(br_sof), .OVF_O(br_ovf), .o_rd_state(br_state)
  );

  cp_symbol_framer #(.N(N), .LOG2N(LOG2N), .BITREV(1'b0)) dut_nat (
    .CLK_I(clk), .RST_I(rst_n), .DAT_I_r(dat_r), .DAT_I_i(dat_i),
    .ACK_I(ack_in), .RDY_I(rdy), .DAT_O_r(nat_dat_r), .DAT_O_i(nat_dat_i),
    .ACK_O(nat_ack), .SOF_O(nat_sof), .OVF_O(nat_ovf), .o_rd_state(nat_state)
  );

  int          cyc = 0;
  bit          rdy_hist [0:65535];
  rec_t        rec_br[$];
  rec_t        rec_nat[$];
  logic [32:0] exp_br_q[$];
  logic [32:0] exp_nat_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  bit          rdy_level = 1'b0;
  bit          rdy_toggle = 1'b0;
  int          last_t = 0;

  always @(posedge clk) begin
    rdy_hist[cyc[15:0]] <= rdy;
    cyc <= cyc + 1;
  end

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    logic [32:0] e;
    if (rst_n && br_ack) begin
      rec_br.push_back('{cyc, br_sof, br_dat_r, br_dat_i});
      n_checks++;
      if (exp_br_q.size() == 0) begin
        n_errors++;
        $display("FAIL sb_br: unexpected output sof=%b r=%h i=%h at cycle %0d", br_sof, br_dat_r, br_dat_i, cyc);
      end else begin
        e = exp_br_q.pop_front();
        if ({br_sof, br_dat_r, br_dat_i} !== e) begin
          n_errors++;
          $display("FAIL sb_br: got sof=%b r=%h i=%h, expected sof=%b r=%h i=%h",
                   br_sof, br_dat_r, br_dat_i, e[32], e[31:16], e[15:0]);
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [32:0] e;
    if (rst_n && nat_ack) begin
      rec_nat.push_back('{cyc, nat_sof, nat_dat_r, nat_dat_i});
      n_checks++;
      if (exp_nat_q.size() == 0) begin
        n_errors++;
        $display("FAIL sb_nat: unexpected output sof=%b r=%h i=%h at cycle %0d", nat_sof, nat_dat_r, nat_dat_i, cyc);
      end else begin
        e = exp_nat_q.pop_front();
        if ({nat_sof, nat_dat_r, nat_dat_i} !== e) begin
          n_errors++;
          $display("FAIL sb_nat: got sof=%b r=%h i=%h, expected sof=%b r=%h i=%h",
                   nat_sof, nat_dat_r, nat_dat_i, e[32], e[31:16], e[15:0]);
        end
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic int rev_idx(int j);
    int r = 0;
    for (int b = 0; b < LOG2N; b++) r = r * 2 + ((j >> b) % 2);
    return r;
  endfunction

  task automatic model_symbol(input logic [31:0] sym [N]);
    for (int k = 0; k < N; k++) begin
      exp_br_q.push_back({k == 0, sym[rev_idx(k)]});
      exp_nat_q.push_back({k == 0, sym[k]});
    end
  endtask

  // ---------------- drivers ----------------
  task automatic drive_cycle(input logic a, input logic [15:0] r, input logic [15:0] i);
    ack_in = a;
    dat_r  = r;
    dat_i  = i;
    rdy    = rdy_toggle ? cyc[0] : rdy_level;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_symbol(input bit ramp, input bit keep, input int gap);
    logic [31:0] sym [N];
    for (int k = 0; k < N; k++) sym[k] = ramp ? {16'(k), 16'(-k)} : $urandom;
    for (int k = 0; k < N; k++) begin
      for (int g = 0; g < gap; g++) drive_cycle(1'b0, 16'h0, 16'h0);
      if (k == N - 1) last_t = cyc;
      drive_cycle(1'b1, sym[k][31:16], sym[k][15:0]);
    end
    ack_in = 1'b0;
    if (keep) model_symbol(sym);
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while ((exp_br_q.size() != 0 || exp_nat_q.size() != 0) && n < budget) begin
      drive_cycle(1'b0, 16'h0, 16'h0);
      n++;
    end
    n_checks++;
    if (exp_br_q.size() != 0 || exp_nat_q.size() != 0) begin
      n_errors++;
      $display("FAIL %s_drain: br=%0d nat=%0d outputs still owed after %0d cycles, expected 0",
               name, exp_br_q.size(), exp_nat_q.size(), n);
    end
    repeat (4) drive_cycle(1'b0, 16'h0, 16'h0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    exp_br_q.delete();
    exp_nat_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    rec_br.delete();
    rec_nat.delete();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rdy_toggle = 1'b0;
    rdy_level  = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({br_ack, br_sof, br_ovf, br_dat_r, br_dat_i, nat_ack, nat_sof, nat_ovf, nat_dat_r, nat_dat_i} !== '0) begin
      n_errors++;
      $display("FAIL reset_outputs: got br=%b%b%b %h %h nat=%b%b%b %h %h, expected all zero",
               br_ack, br_sof, br_ovf, br_dat_r, br_dat_i, nat_ack, nat_sof, nat_ovf, nat_dat_r, nat_dat_i);
    end
    n_checks++;
    if (br_state !== R_IDLE || nat_state !== R_IDLE) begin
      n_errors++;
      $display("FAIL reset_state: got %0d/%0d, expected R_IDLE", br_state, nat_state);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    // Two symbols stored while the FFT is stalled, then two extra samples overflow.
    drive_symbol(1'b0, 1'b1, 0);
    drive_symbol(1'b0, 1'b1, 0);
    drive_cycle(1'b1, 16'h1234, 16'h5678);
    drive_cycle(1'b1, 16'h9abc, 16'hdef0);
    ack_in = 1'b0;
    n_checks++;
    if (br_ovf !== 1'b1 || nat_ovf !== 1'b1) begin
      n_errors++;
      $display("FAIL ovf_before_reset: got %b/%b, expected 1", br_ovf, nat_ovf);
    end
    rdy_level = 1'b1;
    repeat (10) drive_cycle(1'b0, 16'h0, 16'h0);
    n_checks++;
    if (rec_br.size() != 9 || rec_nat.size() != 9) begin
      n_errors++;
      $display("FAIL mid_output_count: got %0d/%0d, expected 9", rec_br.size(), rec_nat.size());
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({br_ack, br_sof, br_ovf, br_dat_r, br_dat_i, nat_ack, nat_sof, nat_ovf, nat_dat_r, nat_dat_i} !== '0
        || br_state !== R_IDLE) begin
      n_errors++;
      $display("FAIL midstream_reset: got br=%b%b%b %h %h nat=%b%b%b %h %h, expected all zero",
               br_ack, br_sof, br_ovf, br_dat_r, br_dat_i, nat_ack, nat_sof, nat_ovf, nat_dat_r, nat_dat_i);
    end
    exp_br_q.delete();
    exp_nat_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    rec_br.delete();
    rec_nat.delete();
    repeat (5) drive_cycle(1'b0, 16'h0, 16'h0);
    n_checks++;
    if (rec_br.size() != 0 || rec_nat.size() != 0 || br_ovf !== 1'b0) begin
      n_errors++;
      $display("FAIL post_reset_quiet: got outputs=%0d/%0d ovf=%b, expected 0/0 ovf=0",
               rec_br.size(), rec_nat.size(), br_ovf);
    end
    drive_symbol(1'b0, 1'b1, 0);
    drain("reset", 300);
    n_checks++;
    if (!(rec_br.size() == N && rec_br[0].cyc == last_t + 2)) begin
      n_errors++;
      $display("FAIL post_reset_symbol0: got %0d outputs, expected %0d starting at cycle %0d", rec_br.size(), N, last_t + 2);
    end
  endtask

  task automatic test_bitrev();
    int exp_r [5] = '{0, 32, 16, 48, 8};
    int nsof = 0;
    rdy_level = 1'b1;
    rec_br.delete();
    rec_nat.delete();
    drive_symbol(1'b1, 1'b1, 0);
    drain("bitrev", 300);
    n_checks++;
    if (rec_br.size() != N) begin
      n_errors++;
      $display("FAIL bitrev_count: got %0d, expected %0d", rec_br.size(), N);
    end else begin
      n_checks++;
      if (rec_br[0].cyc != last_t + 2 || rec_br[N-1].cyc != last_t + 1 + N) begin
        n_errors++;
        $display("FAIL bitrev_timing: got cycles %0d..%0d, expected %0d..%0d",
                 rec_br[0].cyc, rec_br[N-1].cyc, last_t + 2, last_t + 1 + N);
      end
      foreach (rec_br[k]) if (rec_br[k].sof) nsof++;
      n_checks++;
      if (nsof != 1 || rec_br[0].sof !== 1'b1) begin
        n_errors++;
        $display("FAIL bitrev_sof: got %0d SOFs (first=%b), expected 1 on first", nsof, rec_br[0].sof);
      end
      for (int k = 0; k < 5; k++) begin
        n_checks++;
        if (rec_br[k].r !== 16'(exp_r[k])) begin
          n_errors++;
          $display("FAIL bitrev_order[%0d]: got r=%0d, expected %0d", k, rec_br[k].r, exp_r[k]);
        end
      end
      n_checks++;
      if (rec_br[N-1].r !== 16'd63 || rec_br[N-1].i !== 16'hffc1) begin
        n_errors++;
        $display("FAIL bitrev_last: got r=%h i=%h, expected 003f ffc1", rec_br[N-1].r, rec_br[N-1].i);
      end
    end
  endtask

  task automatic test_natural();
    rdy_level = 1'b1;
    rec_br.delete();
    rec_nat.delete();
    drive_symbol(1'b1, 1'b1, 0);
    drain("natural", 300);
    n_checks++;
    if (rec_nat.size() != N) begin
      n_errors++;
      $display("FAIL natural_count: got %0d, expected %0d", rec_nat.size(), N);
    end else begin
      for (int k = 0; k < N; k++) begin
        n_checks++;
        if (rec_nat[k].r !== 16'(k) || rec_nat[k].i !== 16'(-k) || rec_nat[k].sof !== (k == 0)) begin
          n_errors++;
          $display("FAIL natural[%0d]: got r=%h i=%h sof=%b, expected r=%h i=%h sof=%b",
                   k, rec_nat[k].r, rec_nat[k].i, rec_nat[k].sof, 16'(k), 16'(-k), k == 0);
        end
      end
      n_checks++;
      if (rec_nat[0].cyc != last_t + 2) begin
        n_errors++;
        $display("FAIL natural_latency: got cycle %0d, expected %0d", rec_nat[0].cyc, last_t + 2);
      end
    end
  endtask

  task automatic test_back_to_back();
    int t0;
    int bad_sof = 0;
    rdy_level = 1'b1;
    rec_br.delete();
    rec_nat.delete();
    drive_symbol(1'b0, 1'b1, 0);
    t0 = last_t;
    drive_symbol(1'b0, 1'b1, 0);
    drive_symbol(1'b0, 1'b1, 0);
    drain("b2b", 400);
    n_checks++;
    if (rec_br.size() != 3 * N || rec_nat.size() != 3 * N) begin
      n_errors++;
      $display("FAIL b2b_count: got %0d/%0d, expected %0d", rec_br.size(), rec_nat.size(), 3 * N);
    end else begin
      n_checks++;
      if (rec_br[0].cyc != t0 + 2 || rec_br[3*N-1].cyc - rec_br[0].cyc != 3 * N - 1
          || rec_nat[3*N-1].cyc - rec_nat[0].cyc != 3 * N - 1) begin
        n_errors++;
        $display("FAIL b2b_no_bubble: got span %0d starting %0d, expected span %0d starting %0d",
                 rec_br[3*N-1].cyc - rec_br[0].cyc, rec_br[0].cyc, 3 * N - 1, t0 + 2);
      end
      foreach (rec_br[k]) if (rec_br[k].sof !== (k % N == 0)) bad_sof++;
      n_checks++;
      if (bad_sof != 0) begin
        n_errors++;
        $display("FAIL b2b_sof: got %0d misplaced SOFs, expected 0", bad_sof);
      end
    end
    n_checks++;
    if (br_ovf !== 1'b0 || nat_ovf !== 1'b0) begin
      n_errors++;
      $display("FAIL b2b_ovf: got %b/%b, expected 0", br_ovf, nat_ovf);
    end
  endtask

  task automatic test_gaps();
    int bad = 0;
    int idx;
    rec_br.delete();
    rec_nat.delete();
    rdy_toggle = 1'b1;
    drive_symbol(1'b0, 1'b1, 2);
    drive_symbol(1'b0, 1'b1, 2);
    drain("gaps", 1000);
    rdy_toggle = 1'b0;
    n_checks++;
    if (rec_br.size() != 2 * N || rec_nat.size() != 2 * N) begin
      n_errors++;
      $display("FAIL gaps_count: got %0d/%0d, expected %0d", rec_br.size(), rec_nat.size(), 2 * N);
    end
    foreach (rec_br[k]) begin
      idx = rec_br[k].cyc - 1;
      if (!rdy_hist[idx[15:0]]) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_errors++;
      $display("FAIL gaps_hold: got %0d outputs after an RDY_I=0 cycle, expected 0", bad);
    end
    n_checks++;
    if (br_ovf !== 1'b0 || nat_ovf !== 1'b0) begin
      n_errors++;
      $display("FAIL gaps_ovf: got %b/%b, expected 0", br_ovf, nat_ovf);
    end
  endtask

  task automatic test_overflow();
    int nsof = 0;
    do_reset();
    rdy_level = 1'b0;
    drive_symbol(1'b0, 1'b1, 0);
    drive_symbol(1'b0, 1'b1, 0);
    drive_symbol(1'b0, 1'b0, 0);
    n_checks++;
    if (br_ovf !== 1'b1 || nat_ovf !== 1'b1 || rec_br.size() != 0 || br_state !== R_RUN) begin
      n_errors++;
      $display("FAIL ovf_stalled: got ovf=%b/%b outputs=%0d state=%0d, expected ovf=1 outputs=0 state=R_RUN",
               br_ovf, nat_ovf, rec_br.size(), br_state);
    end
    rdy_level = 1'b1;
    drain("ovf", 400);
    foreach (rec_br[k]) if (rec_br[k].sof) nsof++;
    n_checks++;
    if (rec_br.size() != 2 * N || rec_nat.size() != 2 * N || nsof != 2) begin
      n_errors++;
      $display("FAIL ovf_emitted: got %0d/%0d outputs %0d SOFs, expected %0d outputs 2 SOFs",
               rec_br.size(), rec_nat.size(), nsof, 2 * N);
    end
    n_checks++;
    if (br_ovf !== 1'b1 || nat_ovf !== 1'b1) begin
      n_errors++;
      $display("FAIL ovf_sticky: got %b/%b, expected 1", br_ovf, nat_ovf);
    end
  endtask

  initial begin
    test_reset();
    test_bitrev();
    test_natural();
    test_back_to_back();
    test_gaps();
    test_overflow();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
